// File: rtl/color_display_7seg_if.sv
// Signal bundle between the colour source and the 7-segment read-back block.
//   red_i/green_i/blue_i : 4-bit colour bits, synchronous to clk
//   seg                  : cathodes {g,f,e,d,c,b,a}, active-low
//   dp                   : decimal point, active-low
//   an                   : anodes, active-low; an[3]=count, an[2]=R, an[1]=G, an[0]=B
// master drives the colour bits; slave (the display block) drives the panel pins.
interface color_display_7seg_if;
    logic [3:0] red_i;
    logic [3:0] green_i;
    logic [3:0] blue_i;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output red_i, green_i, blue_i,
        input  seg, dp, an
    );

    modport slave (
        input  red_i, green_i, blue_i,
        output seg, dp, an
    );
endinterface

// File: rtl/color_display_7seg.sv
// Shows the R/G/B colour bits in hex on a 4-digit multiplexed 7-segment display,
// plus a 4-bit count of colour changes on the leftmost digit.
// Colours are snapshotted only at frame boundaries, so a frame never mixes old and new
// values. A channel whose value changed blinks for HIGHLIGHT_TICKS digit ticks.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : slave side of color_display_7seg_if (colour inputs, seg/dp/an outputs)
module color_display_7seg #(
    parameter int unsigned CLK_FREQ        = 100_000_000,
    parameter int unsigned DIGIT_RATE      = 4000,
    parameter int unsigned HIGHLIGHT_TICKS = 4000,
    parameter int unsigned BLINK_TICKS     = 500
) (
    input logic                 clk,
    input logic                 rst,
    color_display_7seg_if.slave bus
);

    localparam int unsigned TICK_MAX = CLK_FREQ / DIGIT_RATE;
    localparam int unsigned PRE_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int unsigned TMR_W    = $clog2(HIGHLIGHT_TICKS + 1);
    localparam int unsigned BLK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Channel index matches the anode bit: 2=R, 1=G, 0=B.
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [1:0]            sel_q, sel_d;
    logic [2:0][3:0]       in_q, in_d;
    logic [2:0][3:0]       disp_q, disp_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0][TMR_W-1:0] tmr_q, tmr_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic                  phase_q, phase_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic       tick;
    logic       snap;
    logic [2:0] changed;
    logic [3:0] nib;
    logic       lit_hl;
    logic       blank;

    always_comb begin
        tick  = (pre_q == PRE_W'(TICK_MAX - 1));
        pre_d = tick ? '0 : pre_q + 1'b1;
        sel_d = tick ? sel_q + 2'd1 : sel_q;
        // Frame boundary: the tick that wraps digit_sel from 3 back to 0.
        snap  = tick && (sel_q == 2'd3);

        in_d = {bus.red_i, bus.green_i, bus.blue_i};
        for (int i = 0; i < 3; i++) begin
            changed[i] = snap && (in_q[i] != disp_q[i]);
        end
        disp_d = snap ? in_q : disp_q;
        // One increment per snapshot regardless of how many channels moved.
        cnt_d  = (|changed) ? cnt_q + 4'd1 : cnt_q;

        tmr_d = tmr_q;
        for (int i = 0; i < 3; i++) begin
            if (changed[i]) begin
                tmr_d[i] = TMR_W'(HIGHLIGHT_TICKS);
            end else if (tick && (tmr_q[i] != '0)) begin
                tmr_d[i] = tmr_q[i] - 1'b1;
            end
        end

        blk_d   = blk_q;
        phase_d = phase_q;
        if (tick) begin
            if (blk_q == BLK_W'(BLINK_TICKS - 1)) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + 1'b1;
            end
        end

        nib    = cnt_q;
        lit_hl = 1'b0;
        case (sel_q)
            2'd0: begin nib = disp_q[0]; lit_hl = (tmr_q[0] != '0); end
            2'd1: begin nib = disp_q[1]; lit_hl = (tmr_q[1] != '0); end
            2'd2: begin nib = disp_q[2]; lit_hl = (tmr_q[2] != '0); end
            default: begin nib = cnt_q; lit_hl = 1'b0; end
        endcase
        blank = lit_hl && !phase_q;

        an_d  = blank ? 4'hF : ~(4'b0001 << sel_q);
        seg_d = blank ? 7'h7F : hex7(nib);
        dp_d  = (sel_q != 2'd3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            sel_q   <= '0;
            in_q    <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            sel_q   <= sel_d;
            in_q    <= in_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_color_display_7seg.sv
// Randomised bench for color_display_7seg with a cycle-count based reference model.
module tb_color_display_7seg;

    localparam int TM = 4;  // clocks per tick
    localparam int HT = 8;  // highlight ticks
    localparam int BT = 2;  // blink half-period in ticks

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    color_display_7seg_if bus ();

    color_display_7seg #(
        .CLK_FREQ       (400),
        .DIGIT_RATE     (100),
        .HIGHLIGHT_TICKS(HT),
        .BLINK_TICKS    (BT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks   = 0;
    int failures = 0;

    // Model state: k = clock edges since reset release; channel 0=B, 1=G, 2=R.
    int         k;
    logic [3:0] held    [3];
    logic [3:0] prev_in [3];
    int         load_tick [3];
    int         cnt;

    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic int timer_at(input int ch, input int t);
        int r;
        if (load_tick[ch] < 0) return 0;
        r = HT - (t - load_tick[ch]);
        return (r < 0) ? 0 : r;
    endfunction

    task automatic model_reset();
        k   = 0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            held[i]      = 4'h0;
            prev_in[i]   = 4'h0;
            load_tick[i] = -1;
        end
    endtask

    // One clock: predict the outputs registered at this edge, advance the model, compare.
    task automatic step();
        logic [3:0] cur [3];
        int t, d;
        bit blank, any;
        @(posedge clk);
        cur[0] = bus.blue_i;
        cur[1] = bus.green_i;
        cur[2] = bus.red_i;
        t = k / TM;
        d = t % 4;
        blank = (d < 3) && (timer_at(d, t) > 0) && (((t / BT) % 2) == 0);
        if (blank) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            exp_an  = ~(4'b0001 << d);
            exp_seg = (d == 3) ? hex_tab[cnt] : hex_tab[held[d]];
        end
        exp_dp = (d == 3) ? 1'b0 : 1'b1;

        k++;
        if ((k % TM == 0) && ((k / TM) % 4 == 0)) begin
            any = 0;
            for (int i = 0; i < 3; i++) begin
                if (prev_in[i] != held[i]) begin
                    any          = 1;
                    held[i]      = prev_in[i];
                    load_tick[i] = k / TM;
                end
            end
            if (any) cnt = (cnt + 1) % 16;
        end
        for (int i = 0; i < 3; i++) prev_in[i] = cur[i];

        @(negedge clk);
        check_eq("an", 32'(bus.an), 32'(exp_an));
        check_eq("seg", 32'(bus.seg), 32'(exp_seg));
        check_eq("dp", 32'(bus.dp), 32'(exp_dp));
    endtask

    task automatic rand_change();
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 2))
            0: bus.blue_i = v;
            1: bus.green_i = v;
            default: bus.red_i = v;
        endcase
    endtask

    initial begin
        model_reset();
        bus.red_i   = 4'hA;
        bus.green_i = 4'h5;
        bus.blue_i  = 4'hF;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_an", 32'(bus.an), 32'h0000_000F);
        check_eq("rst_seg", 32'(bus.seg), 32'h0000_007F);
        check_eq("rst_dp", 32'(bus.dp), 32'h0000_0001);
        rst = 1'b1;

        // Static colour from reset.
        repeat (200) step();

        // Mid-frame change of G while digit 1 is being scanned.
        while (((k / TM) % 4) != 1) step();
        bus.green_i = 4'h3;
        repeat (160) step();

        // All three channels change in the same clock.
        bus.red_i   = 4'h1;
        bus.green_i = 4'hC;
        bus.blue_i  = 4'hD;
        repeat (160) step();

        // Change G once per frame for 17 frames to wrap the counter.
        for (int f = 0; f < 17; f++) begin
            bus.green_i = bus.green_i + 4'd1;
            repeat (16) step();
        end
        repeat (64) step();

        // Random activity.
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) rand_change();
            if ($urandom_range(0, 99) == 0) begin
                bus.red_i   = 4'($urandom_range(0, 15));
                bus.green_i = 4'($urandom_range(0, 15));
                bus.blue_i  = 4'($urandom_range(0, 15));
            end
            step();
        end

        // Asynchronous reset while digit 2 is being scanned.
        while (((k / TM) % 4) != 2) step();
        rst = 1'b0;
        #1;
        check_eq("arst_an", 32'(bus.an), 32'h0000_000F);
        check_eq("arst_seg", 32'(bus.seg), 32'h0000_007F);
        check_eq("arst_dp", 32'(bus.dp), 32'h0000_0001);
        @(negedge clk);
        check_eq("arst_hold_an", 32'(bus.an), 32'h0000_000F);
        rst = 1'b1;
        model_reset();

        repeat (600) begin
            if ($urandom_range(0, 19) == 0) rand_change();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
